uart_tx_sched: RTL and testbench
================================

UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
- REQ-001 Parameter: DATA_WIDTH, default 8, UART byte width; channel B carries 2*DATA_WIDTH.
- REQ-002 Parameter: BUSY_TIMEOUT, default 7, cycles allowed in WAIT_BUSY for tx_busy to rise before a retry; legal range 2..15.
- REQ-003 CLK  input  1  single clock; all state updates on its rising edge.
- REQ-004 RST  input  1  asynchronous, active-low reset.
- REQ-005 a_valid  input  1  channel A has a byte ready.
- REQ-006 a_data  input  DATA_WIDTH  channel A byte.
- REQ-007 a_ready  output  1  one-cycle pulse; channel A word accepted.
- REQ-008 b_valid  input  1  channel B has a word ready.
- REQ-009 b_data  input  2*DATA_WIDTH  channel B word, sent LSB byte first.
- REQ-010 b_ready  output  1  one-cycle pulse; channel B word accepted.
- REQ-011 tx_busy  input  1  busy flag from the UART transmitter.
- REQ-012 tx_p_data  output  DATA_WIDTH  byte presented to the UART transmitter.
- REQ-013 tx_data_valid  output  1  one-cycle start strobe to the UART transmitter.
- REQ-014 sched_idle  output  1  high only in IDLE.
- REQ-015 timeout_err  output  1  one-cycle pulse on each WAIT_BUSY timeout.

Function
- REQ-016 The FSM SHALL have the states IDLE, SEND, WAIT_BUSY and WAIT_DONE, plus a 1-bit byte index and a grant register.
- REQ-017 Acceptance: in IDLE with (a_valid|b_valid) and !tx_busy, the block SHALL arbitrate, latch the granted data, pulse the matching ready for that cycle, and move to SEND.
- REQ-018 In IDLE with tx_busy=1, no acceptance SHALL occur.
- REQ-019 Only one of a_ready or b_ready SHALL ever be high in a cycle.
- REQ-020 SEND SHALL last one cycle and assert tx_data_valid=1 with tx_p_data = the current byte, then move to WAIT_BUSY.
- REQ-021 Current byte: a_data for channel A; b_data[DATA_WIDTH-1:0] for channel B index 0; the upper half for index 1.
- REQ-022 tx_p_data SHALL hold the current byte from SEND through WAIT_DONE, and SHALL hold its last value in IDLE.
- REQ-023 WAIT_BUSY: on tx_busy=1, go to WAIT_DONE and clear the timeout counter.
- REQ-024 WAIT_BUSY timeout: after BUSY_TIMEOUT cycles without tx_busy, pulse timeout_err and return to SEND with the same byte (retry, no limit).
- REQ-025 WAIT_DONE: on tx_busy=0, a channel B word with index 0 SHALL set index=1 and go to SEND; otherwise go to IDLE.
- REQ-026 Minimum latency: acceptance to tx_data_valid is 1 cycle; the second byte of B is strobed 1 cycle after busy falls.
- REQ-027 A channel B word SHALL never be interleaved with channel A bytes.
- REQ-028 Input data changing after acceptance SHALL not affect the bytes transmitted.

Reset
- REQ-029 While RST=0, the block SHALL be in state IDLE with index=0 and the timeout counter at 0.
- REQ-030 While RST=0, the outputs SHALL be tx_data_valid=0, tx_p_data=0, a_ready=0, b_ready=0, timeout_err=0 and sched_idle=1.
- REQ-031 The grant register SHALL reset to "last granted = B", so channel A wins the first tie.
- REQ-032 Reset mid-word SHALL abandon the remaining bytes; the abandoned word is not re-requested.

Configuration
- REQ-033 The macro UART_TX_SCHED_RR_EN SHALL select the arbitration scheme.
- REQ-034 With UART_TX_SCHED_RR_EN defined: round-robin; on a tie, the channel not granted last SHALL win, and the grant register updates on each acceptance.
- REQ-035 With UART_TX_SCHED_RR_EN undefined: fixed priority, B over A; the grant register is unused.
- REQ-036 The interface SHALL be identical in both configurations.

Verification
- REQ-037 Single A: a_valid=1, a_data=0x5A, and the UART model raises busy 1 cycle after the strobe for 10 cycles -> a_ready 1 cycle, then tx_data_valid 1 cycle with tx_p_data=0x5A, then sched_idle=1 after busy falls.
- REQ-038 Single B: b_data=0xBEEF -> exactly two strobes, 0xEF then 0xBE; the second strobe comes 1 cycle after busy falls; one b_ready pulse.
- REQ-039 Tie, RR build: both channels held valid for 4 words -> grant order A,B,A,B; fixed build -> B,B,B,B while B stays valid.
- REQ-040 Timeout: UART model never raises busy, BUSY_TIMEOUT=7 -> timeout_err pulse, then a re-strobe of the same byte 8 cycles after the first strobe, repeating.
- REQ-041 Reset mid-word: RST=0 during WAIT_DONE of B byte 0 -> all outputs at reset values; after release, no second-byte strobe occurs.

Source files
------------

// File: rtl/uart_tx_sched.sv
// Two-channel byte scheduler feeding a single UART transmitter: channel A sends one byte, channel B sends a
// two-byte word (low byte first, never interleaved). Define UART_TX_SCHED_RR_EN for round-robin arbitration; default is fixed B-over-A.
module uart_tx_sched #(
    parameter int DATA_WIDTH   = 8,
    parameter int BUSY_TIMEOUT = 7
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    a_valid,
    input  logic [DATA_WIDTH-1:0]   a_data,
    output logic                    a_ready,
    input  logic                    b_valid,
    input  logic [2*DATA_WIDTH-1:0] b_data,
    output logic                    b_ready,
    input  logic                    tx_busy,
    output logic [DATA_WIDTH-1:0]   tx_p_data,
    output logic                    tx_data_valid,
    output logic                    sched_idle,
    output logic                    timeout_err
);
    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    localparam logic [3:0] TMO_LAST = 4'(BUSY_TIMEOUT - 1);

    state_t                state_q, state_d;
    logic                  idx_q, idx_d;
    logic                  chan_b_q, chan_b_d;
    logic [DATA_WIDTH-1:0] hi_q, hi_d;
    logic [DATA_WIDTH-1:0] byte_q, byte_d;
    logic [3:0]            tmo_cnt_q, tmo_cnt_d;
    logic                  grant_b;
    logic                  accept;

    assign accept = (state_q == IDLE) && (a_valid || b_valid) && !tx_busy;

`ifdef UART_TX_SCHED_RR_EN
    logic last_b_q, last_b_d;

    // On a tie the channel that did not win last time goes first.
    always_comb begin
        grant_b  = b_valid && (!a_valid || !last_b_q);
        last_b_d = accept ? grant_b : last_b_q;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            last_b_q <= 1'b1;
        end else begin
            last_b_q <= last_b_d;
        end
    end
`else
    always_comb begin
        grant_b = b_valid;
    end
`endif

    // Ready is combinational in the accepting cycle; gate with reset so it stays low while held.
    assign a_ready       = accept && !grant_b && RST;
    assign b_ready       = accept && grant_b && RST;
    assign tx_data_valid = (state_q == SEND);
    assign sched_idle    = (state_q == IDLE);
    assign tx_p_data     = byte_q;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        chan_b_d    = chan_b_q;
        hi_d        = hi_q;
        byte_d      = byte_q;
        tmo_cnt_d   = tmo_cnt_q;
        timeout_err = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    chan_b_d = grant_b;
                    idx_d    = 1'b0;
                    byte_d   = grant_b ? b_data[DATA_WIDTH-1:0] : a_data;
                    if (grant_b) begin
                        hi_d = b_data[2*DATA_WIDTH-1:DATA_WIDTH];
                    end
                    state_d = SEND;
                end
            end
            SEND: begin
                tmo_cnt_d = '0;
                state_d   = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    tmo_cnt_d = '0;
                    state_d   = WAIT_DONE;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    // Transmitter never acknowledged: strobe the same byte again.
                    timeout_err = 1'b1;
                    tmo_cnt_d   = '0;
                    state_d     = SEND;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 4'd1;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    if (chan_b_q && !idx_q) begin
                        idx_d   = 1'b1;
                        byte_d  = hi_q;
                        state_d = SEND;
                    end else begin
                        idx_d   = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= IDLE;
            idx_q     <= 1'b0;
            chan_b_q  <= 1'b0;
            hi_q      <= '0;
            byte_q    <= '0;
            tmo_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            chan_b_q  <= chan_b_d;
            hi_q      <= hi_d;
            byte_q    <= byte_d;
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: directed scenarios plus randomized traffic checked against a transaction-level
// arbitration/byte-stream model, with a simple UART model answering each strobe with a busy window.
module tb_uart_tx_sched;
    localparam int DW  = 8;
    localparam int BW  = 2 * DW;
    localparam int TMO = 7;
`ifdef UART_TX_SCHED_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          CLK = 1'b0;
    logic          rst_n;
    logic          a_valid, b_valid, a_ready, b_ready;
    logic [DW-1:0] a_data;
    logic [BW-1:0] b_data;
    logic          tx_busy, tx_data_valid, sched_idle, timeout_err;
    logic [DW-1:0] tx_p_data;

    logic uart_busy = 1'b0, busy_force = 1'b0, uart_on = 1'b0, uart_req = 1'b0;
    int   busy_len = 10, busy_left = 0;
    int   cyc = 0, checks = 0, errors = 0;

    int            s_cyc[$], r_cyc[$], t_cyc[$];
    logic [DW-1:0] s_byte[$];
    logic [DW-1:0] exp_q[$];
    bit            r_b[$];

    always #5 CLK = ~CLK;
    assign tx_busy = uart_busy | busy_force;

    uart_tx_sched #(.DATA_WIDTH(DW), .BUSY_TIMEOUT(TMO)) dut (
        .CLK(CLK), .RST(rst_n),
        .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
        .tx_busy(tx_busy), .tx_p_data(tx_p_data), .tx_data_valid(tx_data_valid),
        .sched_idle(sched_idle), .timeout_err(timeout_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Winner of an acceptance given which channels are offering and who won last.
    function automatic bit pick_b(input bit va, input bit vb, input bit last_b);
        if (va && vb) return RR ? !last_b : 1'b1;
        return vb;
    endfunction

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        uart_req = tx_data_valid && uart_on;
        if (tx_data_valid) begin
            s_cyc.push_back(cyc);
            s_byte.push_back(tx_p_data);
        end
        if (a_ready || b_ready) begin
            r_cyc.push_back(cyc);
            r_b.push_back(b_ready);
            chk("ready_onehot", 32'(a_ready & b_ready), 32'd0);
        end
        if (timeout_err) t_cyc.push_back(cyc);
    end

    // UART model: busy rises the cycle after a strobe and stays up for busy_len cycles.
    always @(posedge CLK) begin
        #1;
        if (uart_req) begin
            uart_busy = 1'b1;
            busy_left = busy_len;
        end else if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) uart_busy = 1'b0;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic clear_logs();
        s_cyc.delete(); r_cyc.delete(); t_cyc.delete(); s_byte.delete(); r_b.delete();
    endtask

    task automatic wait_rdy(input string tag, input int limit);
        bit seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge CLK);
            seen = a_ready || b_ready;
        end
        chk({tag, "_ready_seen"}, 32'(seen), 32'd1);
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        @(negedge CLK);
        chk({tag, "_tx_valid"}, 32'(tx_data_valid), 32'd0);
        chk({tag, "_tx_data"},  32'(tx_p_data),     32'd0);
        chk({tag, "_a_ready"},  32'(a_ready),       32'd0);
        chk({tag, "_b_ready"},  32'(b_ready),       32'd0);
        chk({tag, "_tmo_err"},  32'(timeout_err),   32'd0);
        chk({tag, "_idle"},     32'(sched_idle),    32'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached before the end of the sequence");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [BW-1:0] w;
        logic [DW-1:0] d;
        bit            grants[4];
        int            ngrant;
        bit            last_b, e, got_a, got_b, seen;

        // Reset with both channels offering: nothing may be accepted.
        rst_n = 1'b0; a_valid = 1'b1; b_valid = 1'b1;
        a_data = DW'($urandom); b_data = BW'($urandom);
        tick(2);
        chk_reset("rst");
        tick(1);
        a_valid = 1'b0; b_valid = 1'b0; rst_n = 1'b1;
        tick(2);

        // Single A byte.
        clear_logs(); uart_on = 1'b1; busy_len = 10;
        a_data = 8'h5A; a_valid = 1'b1;
        wait_rdy("a_single", 10);
        a_valid = 1'b0; a_data = 8'hA5;
        tick(20);
        @(negedge CLK);
        chk("a_nready",  32'(r_cyc.size()), 32'd1);
        chk("a_ready_b", 32'(r_b[0]), 32'd0);
        chk("a_nstrobe", 32'(s_cyc.size()), 32'd1);
        chk("a_byte",    32'(s_byte[0]), 32'h5A);
        chk("a_latency", 32'(s_cyc[0] - r_cyc[0]), 32'd1);
        chk("a_idle",    32'(sched_idle), 32'd1);
        chk("a_hold",    32'(tx_p_data), 32'h5A);
        tick(1);

        // Single B word: low byte, then high byte one cycle after busy falls.
        clear_logs();
        b_data = 16'hBEEF; b_valid = 1'b1;
        wait_rdy("b_single", 10);
        b_valid = 1'b0; b_data = 16'h1234;
        tick(30);
        @(negedge CLK);
        chk("b_nready",  32'(r_cyc.size()), 32'd1);
        chk("b_ready_b", 32'(r_b[0]), 32'd1);
        chk("b_nstrobe", 32'(s_cyc.size()), 32'd2);
        chk("b_byte0",   32'(s_byte[0]), 32'hEF);
        chk("b_byte1",   32'(s_byte[1]), 32'hBE);
        chk("b_latency", 32'(s_cyc[0] - r_cyc[0]), 32'd1);
        chk("b_gap",     32'(s_cyc[1] - s_cyc[0]), 32'(busy_len + 2));
        chk("b_idle",    32'(sched_idle), 32'd1);
        tick(1);

        // Tie after reset: both channels held valid for four words.
        rst_n = 1'b0;
        chk_reset("rst2");
        tick(1);
        rst_n = 1'b1;
        tick(1);
        clear_logs(); exp_q.delete(); busy_len = 3; ngrant = 0;
        a_data = DW'($urandom); b_data = BW'($urandom); a_valid = 1'b1; b_valid = 1'b1;
        for (int i = 0; i < 300 && ngrant < 4; i++) begin
            @(negedge CLK);
            got_a = a_ready; got_b = b_ready;
            if (got_a || got_b) begin
                grants[ngrant] = got_b;
                ngrant++;
                if (got_b) begin
                    exp_q.push_back(b_data[DW-1:0]);
                    exp_q.push_back(b_data[BW-1:DW]);
                end else begin
                    exp_q.push_back(a_data);
                end
            end
            @(posedge CLK);
            #1;
            if (got_b) b_data = BW'($urandom);
            else if (got_a) a_data = DW'($urandom);
        end
        a_valid = 1'b0; b_valid = 1'b0;
        tick(30);
        chk("tie_ngrant", 32'(ngrant), 32'd4);
        last_b = 1'b1;
        for (int k = 0; k < 4; k++) begin
            e = pick_b(1'b1, 1'b1, last_b);
            last_b = e;
            chk($sformatf("tie_grant%0d", k), 32'(grants[k]), 32'(e));
        end
        chk("tie_nbytes", 32'(s_byte.size()), 32'(exp_q.size()));
        for (int k = 0; k < exp_q.size(); k++)
            chk($sformatf("tie_byte%0d", k), 32'(s_byte[k]), 32'(exp_q[k]));

        // Busy held in IDLE blocks acceptance; then a transmitter that never answers.
        uart_on = 1'b0; busy_force = 1'b1;
        d = DW'($urandom); a_data = d; a_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            chk("busy_no_ready", 32'(a_ready | b_ready), 32'd0);
        end
        tick(1);
        busy_force = 1'b0;
        clear_logs();
        wait_rdy("tmo", 10);
        a_valid = 1'b0; a_data = ~d;
        tick(26);
        @(negedge CLK);
        chk("tmo_nstrobe", 32'(s_cyc.size()), 32'd4);
        for (int k = 0; k < 3; k++) chk($sformatf("tmo_byte%0d", k), 32'(s_byte[k]), 32'(d));
        for (int k = 1; k < 3; k++) chk($sformatf("tmo_gap%0d", k), 32'(s_cyc[k] - s_cyc[k-1]), 32'(TMO + 1));
        chk("tmo_first", 32'(t_cyc[0] - s_cyc[0]), 32'(TMO));
        chk("tmo_npulse", 32'(t_cyc.size()), 32'd3);
        tick(1);
        uart_on = 1'b1; busy_len = 2;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge CLK);
            seen = sched_idle;
        end
        chk("tmo_recover", 32'(seen), 32'd1);
        tick(1);

        // Reset during WAIT_DONE of B byte 0 drops the high byte.
        clear_logs(); busy_len = 10;
        w = BW'($urandom); b_data = w; b_valid = 1'b1;
        wait_rdy("mid", 10);
        b_valid = 1'b0; b_data = ~w;
        tick(4);
        rst_n = 1'b0;
        chk_reset("mid_rst");
        chk("mid_byte0", 32'(s_byte[0]), 32'(w[DW-1:0]));
        tick(2);
        rst_n = 1'b1;
        clear_logs();
        tick(30);
        @(negedge CLK);
        chk("mid_nstrobe", 32'(s_cyc.size()), 32'd0);
        chk("mid_idle", 32'(sched_idle), 32'd1);
        tick(1);

        // Randomized traffic against the arbitration and byte-stream model.
        clear_logs(); exp_q.delete(); last_b = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge CLK);
            got_a = a_ready; got_b = b_ready;
            busy_len = $urandom_range(1, 5);
            if (got_a || got_b) begin
                e = pick_b(a_valid, b_valid, last_b);
                last_b = e;
                chk("rand_grant", 32'({got_a, got_b}), 32'({!e, e}));
                if (e) begin
                    exp_q.push_back(b_data[DW-1:0]);
                    exp_q.push_back(b_data[BW-1:DW]);
                end else begin
                    exp_q.push_back(a_data);
                end
            end
            @(posedge CLK);
            #1;
            if (got_a) a_valid = 1'b0;
            if (got_b) b_valid = 1'b0;
            if (!a_valid && $urandom_range(0, 2) == 0) begin
                a_data = DW'($urandom); a_valid = 1'b1;
            end
            if (!b_valid && $urandom_range(0, 2) == 0) begin
                b_data = BW'($urandom); b_valid = 1'b1;
            end
        end
        a_valid = 1'b0; b_valid = 1'b0;
        tick(40);
        chk("rand_nbytes", 32'(s_byte.size()), 32'(exp_q.size()));
        for (int k = 0; k < exp_q.size(); k++)
            chk($sformatf("rand_byte%0d", k), 32'(s_byte[k]), 32'(exp_q[k]));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
